// File: rtl/display_share_arbiter.sv
// Round-robin owner arbiter for the shared 8-digit seven-segment display driver.
// Optional blank GAP state between owners is enabled with `define DISP_GAP_EN.
module display_share_arbiter #(
  parameter int          NUM_REQ     = 2,
  parameter int          HOLD_CYCLES = 100_000_000,
  parameter int          GAP_CYCLES  = 10_000_000,
  parameter logic [31:0] IDLE_DATA   = 32'h0000_0000,
  localparam int         CW          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [CW-1:0]         owner,
  output logic [31:0]           disp_data,
  output logic                  disp_enable
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef DISP_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_GAP = 2'd2} state_t;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1} state_t;
`endif

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [CW-1:0]        owner_reg, owner_next;
  logic [CW-1:0]        last_owner_reg, last_owner_next;
  logic [31:0]          disp_data_reg, disp_data_next;
  logic                 disp_enable_reg, disp_enable_next;
  logic [HW-1:0]        hold_cnt_reg, hold_cnt_next;

  logic [31:0]          data_arr [NUM_REQ];
  logic                 pick_valid;
  logic [CW-1:0]        pick_idx;
  logic [CW-1:0]        cand;
  int                   pick_pos;
  logic                 take_owner, release_all, switch_owner;
  logic                 owner_req, contender;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[32*gi +: 32];
    end
  endgenerate

  // Descending scan so the nearest requester after last_owner wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_pos   = 0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pick_pos = (int'(last_owner_reg) + k) % NUM_REQ;
      cand     = CW'(pick_pos);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_req = req[owner_reg];
  assign contender = |(req & ~gnt_reg);

  always_comb begin
    state_next       = state_reg;
    gnt_next         = gnt_reg;
    owner_next       = owner_reg;
    last_owner_next  = last_owner_reg;
    disp_data_next   = disp_data_reg;
    disp_enable_next = disp_enable_reg;
    hold_cnt_next    = hold_cnt_reg;
`ifdef DISP_GAP_EN
    gap_cnt_next     = gap_cnt_reg;
`endif
    take_owner       = 1'b0;
    release_all      = 1'b0;
    switch_owner     = 1'b0;

    case (state_reg)
      ST_IDLE: take_owner = pick_valid;
      ST_GRANT: begin
        if (!owner_req) begin
          if (pick_valid) switch_owner = 1'b1;
          else            release_all  = 1'b1;
        end else if (hold_cnt_reg == '0 && contender) begin
          switch_owner = 1'b1;
        end else begin
          disp_data_next = data_arr[owner_reg];
          if (hold_cnt_reg != '0) hold_cnt_next = hold_cnt_reg - HW'(1);
        end
      end
`ifdef DISP_GAP_EN
      ST_GAP: begin
        if (gap_cnt_reg == '0) begin
          if (pick_valid) take_owner  = 1'b1;
          else            release_all = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg - GW'(1);
        end
      end
`endif
      default: release_all = 1'b1;
    endcase

`ifdef DISP_GAP_EN
    // Owner-to-owner handover blanks the display before the new pick.
    if (switch_owner) begin
      state_next       = ST_GAP;
      gnt_next         = '0;
      disp_enable_next = 1'b0;
      disp_data_next   = IDLE_DATA;
      gap_cnt_next     = GW'(GAP_CYCLES - 1);
    end
`else
    if (switch_owner) take_owner = 1'b1;
`endif

    if (take_owner) begin
      state_next          = ST_GRANT;
      gnt_next            = '0;
      gnt_next[pick_idx]  = 1'b1;
      owner_next          = pick_idx;
      last_owner_next     = pick_idx;
      disp_data_next      = data_arr[pick_idx];
      disp_enable_next    = 1'b1;
      hold_cnt_next       = HW'(HOLD_CYCLES - 1);
    end

    if (release_all) begin
      state_next       = ST_IDLE;
      gnt_next         = '0;
      disp_enable_next = 1'b0;
      disp_data_next   = IDLE_DATA;
      hold_cnt_next    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      gnt_reg         <= '0;
      owner_reg       <= '0;
      last_owner_reg  <= CW'(NUM_REQ - 1);
      disp_data_reg   <= IDLE_DATA;
      disp_enable_reg <= 1'b0;
      hold_cnt_reg    <= '0;
`ifdef DISP_GAP_EN
      gap_cnt_reg     <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      owner_reg       <= owner_next;
      last_owner_reg  <= last_owner_next;
      disp_data_reg   <= disp_data_next;
      disp_enable_reg <= disp_enable_next;
      hold_cnt_reg    <= hold_cnt_next;
`ifdef DISP_GAP_EN
      gap_cnt_reg     <= gap_cnt_next;
`endif
    end
  end

  assign gnt         = gnt_reg;
  assign owner       = owner_reg;
  assign disp_data   = disp_data_reg;
  assign disp_enable = disp_enable_reg;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Scoreboard bench for display_share_arbiter: a cycle-level reference model
// pushes expected outputs at each rising edge, a monitor compares at the falling edge.
module tb_display_share_arbiter;

  localparam int          N    = 2;
  localparam int          HOLD = 4;
  localparam int          GAP  = 3;
  localparam logic [31:0] IDLE = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [63:0]   req_data;
  logic [N-1:0]  gnt;
  logic [0:0]    owner;
  logic [31:0]   disp_data;
  logic          disp_enable;

  display_share_arbiter #(
    .NUM_REQ(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .IDLE_DATA(IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .owner(owner), .disp_data(disp_data), .disp_enable(disp_enable)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [0:0]   owner;
    logic [31:0]  data;
    logic         en;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: owner tenure measured in owned cycles, not a countdown.
  int   m_mode;   // 0 idle, 1 owned, 2 blank gap
  int   m_owner, m_last, m_owned, m_gap;
  exp_t m_out;
  logic [31:0] dw [N];

  function automatic int rr_pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic start_owner(int w);
    m_mode = 1; m_owner = w; m_last = w; m_owned = 0;
    m_out.gnt = N'(1 << w); m_out.owner = 1'(w); m_out.data = dw[w]; m_out.en = 1'b1;
  endtask

  task automatic go_blank(int nxt_mode);
    m_mode = nxt_mode;
    m_out.gnt = '0; m_out.data = IDLE; m_out.en = 1'b0;
  endtask

  task automatic hand_over(int w);
`ifdef DISP_GAP_EN
    go_blank(2);
    m_gap = GAP;
    if (w < 0) m_gap = GAP;
`else
    start_owner(w);
`endif
  endtask

  task automatic model_step();
    int w;
    dw[0] = req_data[31:0];
    dw[1] = req_data[63:32];
    w = rr_pick(req, m_last);
    if (!rst_n) begin
      m_mode = 0; m_owner = 0; m_last = N - 1; m_owned = 0; m_gap = 0;
      m_out = '{gnt: '0, owner: '0, data: IDLE, en: 1'b0};
    end else begin
      case (m_mode)
        0: if (w >= 0) start_owner(w);
        1: begin
          m_owned++;
          if (!req[m_owner]) begin
            if (w >= 0) hand_over(w);
            else        go_blank(0);
          end else if (m_owned >= HOLD && (req & ~N'(1 << m_owner)) != '0) begin
            hand_over(w);
          end else begin
            m_out.data = dw[m_owner];
          end
        end
        default: begin
          m_gap--;
          if (m_gap == 0) begin
            if (w >= 0) start_owner(w);
            else        go_blank(0);
          end
        end
      endcase
    end
    exp_q.push_back(m_out);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: one comparison per presented output cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt !== e.gnt || owner !== e.owner || disp_data !== e.data || disp_enable !== e.en) begin
          errors++;
          $display("FAIL outputs t=%0t got gnt=%b owner=%0d data=%h en=%b want gnt=%b owner=%0d data=%h en=%b",
                   $time, gnt, owner, disp_data, disp_enable, e.gnt, e.owner, e.data, e.en);
        end else begin
          $display("txn %0d t=%0t req=%b gnt=%b owner=%0d data=%h en=%b",
                   checks, $time, req, gnt, owner, disp_data, disp_enable);
        end
      end
    end
  end

  task automatic check_reset_now(string name);
    checks++;
    if (gnt !== '0 || owner !== '0 || disp_data !== IDLE || disp_enable !== 1'b0) begin
      errors++;
      $display("FAIL %s got gnt=%b owner=%0d data=%h en=%b want all reset values",
               name, gnt, owner, disp_data, disp_enable);
    end
  endtask

  task automatic drive(logic [N-1:0] r, logic [31:0] d0, logic [31:0] d1, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req      = r;
      req_data = {d1, d0};
    end
  endtask

  // Drop rst_n between clock edges and check outputs clear without an edge.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_now("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b1;
    req      = 2'b11;
    req_data = {32'h5555_AAAA, 32'h1234_ABCD};
    #1 rst_n = 1'b0;
    #1 check_reset_now("reset_at_start");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b00;

    // Single requester, then data follows with one cycle lag.
    drive(2'b01, 32'h1234_ABCD, 32'h0, 3);
    drive(2'b01, 32'hDEAD_BEEF, 32'h0, 2);
    drive(2'b00, 32'h0, 32'h0, 2);
    // Contention: hold then alternate.
    drive(2'b01, 32'hAAAA_0000, 32'hBBBB_1111, 1);
    drive(2'b11, 32'hAAAA_0000, 32'hBBBB_1111, 14);
    drive(2'b00, 32'h0, 32'h0, 2);
    // Owner drops before hold expiry, then everyone drops.
    drive(2'b01, 32'hC0C0_C0C0, 32'hD1D1_D1D1, 2);
    drive(2'b11, 32'hC0C0_C0C0, 32'hD1D1_D1D1, 1);
    drive(2'b10, 32'hC0C0_C0C0, 32'hD1D1_D1D1, 3);
    drive(2'b00, 32'h0, 32'h0, 3);
    // Reset mid-grant, then last owner preserved across idle.
    drive(2'b11, 32'h0000_0001, 32'h0000_0002, 3);
    async_reset();
    drive(2'b11, 32'h0000_0003, 32'h0000_0004, 2);
    drive(2'b00, 32'h0, 32'h0, 2);
    drive(2'b11, 32'h0000_0005, 32'h0000_0006, 2);
    drive(2'b00, 32'h0, 32'h0, 2);

    // Random sticky requests with occasional data churn.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 3) == 0) req_data[31:0]  = $urandom;
      if ($urandom_range(0, 3) == 0) req_data[63:32] = $urandom;
      if (c == 1500) async_reset();
    end

    repeat (3) @(negedge clk);
    if (checks < 1000) begin
      errors++;
      $display("FAIL check_count got %0d want at least 1000", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
